// File: rtl/skew_tile_streamer.sv
// Skews a ROWS x COLS tile into ROWS+COLS-1 lanes, one row (or column) per beat, for a systolic array edge.
// Optional SKEW_TILE_COUNT_EN adds tile_count and stall_cycles counters.
module skew_tile_streamer #(
    parameter int ROWS       = 3,
    parameter int COLS       = 3,
    parameter int DATA_WIDTH = 8,
    localparam int LANES     = ROWS + COLS - 1,
    localparam int MAXD      = (ROWS > COLS) ? ROWS : COLS,
    localparam int BEAT_W    = (MAXD > 1) ? $clog2(MAXD) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0]   in_tile,
    input  logic [ROWS*COLS-1:0]              in_mask,
    input  logic                              in_transpose,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES*DATA_WIDTH-1:0]       out_data,
    output logic [LANES-1:0]                  out_mask,
    output logic [BEAT_W-1:0]                 out_beat,
    output logic                              out_last
`ifdef SKEW_TILE_COUNT_EN
    ,
    output logic [15:0]                       tile_count,
    output logic [15:0]                       stall_cycles
`endif
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state_q, state_d;

    logic [ROWS*COLS*DATA_WIDTH-1:0] tile_q;
    logic [ROWS*COLS-1:0]            mask_q;
    logic                            trans_q;

    logic accept;
    logic advance;

    logic [ROWS*COLS*DATA_WIDTH-1:0] src_tile;
    logic [ROWS*COLS-1:0]            src_mask;
    logic                            src_t;
    int                              src_k;
    logic [LANES*DATA_WIDTH-1:0]     beat_data;
    logic [LANES-1:0]                beat_mask;
    logic                            beat_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // in_ready looks through to out_ready so a new tile can land in the last-beat cycle
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        advance  = out_valid && out_ready;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = STREAM;
            end
            STREAM: begin
                in_ready = out_last && out_ready;
                if (advance && out_last && !in_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        accept = in_valid && in_ready;
    end

    // Element (r,c) always lands on lane r+c; the beat index selects by row or by column
    always_comb begin
        src_tile = tile_q;
        src_mask = mask_q;
        src_t    = trans_q;
        src_k    = int'(out_beat) + 1;
        if (accept) begin
            src_tile = in_tile;
            src_mask = in_mask;
            src_t    = in_transpose;
            src_k    = 0;
        end
        beat_data = '0;
        beat_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((src_t ? c : r) == src_k) begin
                    beat_data[(r+c)*DATA_WIDTH +: DATA_WIDTH] = src_tile[(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH];
                    beat_mask[r+c] = src_mask[r*COLS+c];
                end
            end
        end
        beat_last = (src_k == ((src_t ? COLS : ROWS) - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_q    <= '0;
            mask_q    <= '0;
            trans_q   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
            out_beat  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            tile_q    <= in_tile;
            mask_q    <= in_mask;
            trans_q   <= in_transpose;
            out_valid <= 1'b1;
            out_data  <= beat_data;
            out_mask  <= beat_mask;
            out_beat  <= '0;
            out_last  <= beat_last;
        end else if (advance) begin
            if (out_last) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_mask  <= '0;
                out_beat  <= '0;
                out_last  <= 1'b0;
            end else begin
                out_data  <= beat_data;
                out_mask  <= beat_mask;
                out_beat  <= out_beat + 1'b1;
                out_last  <= beat_last;
            end
        end
    end

`ifdef SKEW_TILE_COUNT_EN
    // tile_count wraps naturally; stall_cycles saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (advance && out_last)
                tile_count <= tile_count + 16'd1;
            if (out_valid && !out_ready && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_skew_tile_streamer.sv
// Scoreboard bench for skew_tile_streamer: a 3x3 instance and a 2x4 instance share clock and reset.
module tb_skew_tile_streamer;

    typedef struct packed {
        logic [39:0] data;
        logic [4:0]  mask;
        logic [1:0]  beat;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid_a = 1'b0, in_ready_a, in_transpose_a = 1'b0;
    logic [71:0] in_tile_a = '0;
    logic [8:0]  in_mask_a = '0;
    logic        out_valid_a, out_ready_a = 1'b1, out_last_a;
    logic [39:0] out_data_a;
    logic [4:0]  out_mask_a;
    logic [1:0]  out_beat_a;

    logic        in_valid_b = 1'b0, in_ready_b, in_transpose_b = 1'b0;
    logic [63:0] in_tile_b = '0;
    logic [7:0]  in_mask_b = '0;
    logic        out_valid_b, out_ready_b = 1'b1, out_last_b;
    logic [39:0] out_data_b;
    logic [4:0]  out_mask_b;
    logic [1:0]  out_beat_b;

`ifdef SKEW_TILE_COUNT_EN
    logic [15:0] tile_count_a, stall_cycles_a, tile_count_b, stall_cycles_b;
    logic [15:0] tc_before;
`endif

    int total = 0;
    int bad   = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    skew_tile_streamer #(.ROWS(3), .COLS(3), .DATA_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_tile(in_tile_a),
        .in_mask(in_mask_a), .in_transpose(in_transpose_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_mask(out_mask_a), .out_beat(out_beat_a), .out_last(out_last_a)
`ifdef SKEW_TILE_COUNT_EN
        , .tile_count(tile_count_a), .stall_cycles(stall_cycles_a)
`endif
    );

    skew_tile_streamer #(.ROWS(2), .COLS(4), .DATA_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_tile(in_tile_b),
        .in_mask(in_mask_b), .in_transpose(in_transpose_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_mask(out_mask_b), .out_beat(out_beat_b), .out_last(out_last_b)
`ifdef SKEW_TILE_COUNT_EN
        , .tile_count(tile_count_b), .stall_cycles(stall_cycles_b)
`endif
    );

    function automatic logic [39:0] mk(input logic [7:0] l0, l1, l2, l3, l4);
        return {l4, l3, l2, l1, l0};
    endfunction

    function automatic logic [71:0] seq9(input int base);
        logic [71:0] t;
        t = '0;
        for (int i = 0; i < 9; i++) t[i*8 +: 8] = 8'(base + i);
        return t;
    endfunction

    function automatic logic [63:0] seq8(input int base);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) t[i*8 +: 8] = 8'(base + i);
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectBeat(input int which, input logic [39:0] d, input logic [4:0] m,
                              input logic [1:0] b, input logic l);
        exp_t e;
        e = '{data: d, mask: m, beat: b, last: l};
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    // Offers one tile and returns right after the accepting edge with in_valid dropped
    task automatic applyStimulus(input int which, input logic [71:0] tile, input logic [8:0] mask,
                                 input logic trans);
        int n;
        n = 0;
        if (which == 0) begin
            in_tile_a = tile; in_mask_a = mask; in_transpose_a = trans; in_valid_a = 1'b1;
            while (!in_ready_a && n < 50) begin tick(); n++; end
        end else begin
            in_tile_b = tile[63:0]; in_mask_b = mask[7:0]; in_transpose_b = trans; in_valid_b = 1'b1;
            while (!in_ready_b && n < 50) begin tick(); n++; end
        end
        if (n >= 50) checkOutput("accept_timeout", 64'(n), 64'd0);
        tick();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic waitDrain(input int which);
        int n;
        n = 0;
        while (((which == 0) ? q_a.size() : q_b.size()) != 0 && n < 50) begin tick(); n++; end
        checkOutput((which == 0) ? "drain_a" : "drain_b",
                    64'((which == 0) ? q_a.size() : q_b.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL a_unexpected_beat: got data 0x%0h expected no beat", out_data_a);
            end else begin
                ea = q_a.pop_front();
                checkOutput("a_data", 64'(out_data_a), 64'(ea.data));
                checkOutput("a_mask", 64'(out_mask_a), 64'(ea.mask));
                checkOutput("a_beat", 64'(out_beat_a), 64'(ea.beat));
                checkOutput("a_last", 64'(out_last_a), 64'(ea.last));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("[TB] FAIL b_unexpected_beat: got data 0x%0h expected no beat", out_data_b);
            end else begin
                eb = q_b.pop_front();
                checkOutput("b_data", 64'(out_data_b), 64'(eb.data));
                checkOutput("b_mask", 64'(out_mask_b), 64'(eb.mask));
                checkOutput("b_beat", 64'(out_beat_b), 64'(eb.beat));
                checkOutput("b_last", 64'(out_last_b), 64'(eb.last));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #2;
        checkOutput("reset_out_valid", 64'(out_valid_a), 64'd0);
        checkOutput("reset_out_data", 64'(out_data_a), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready_a), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // 3x3 row mode
        expectBeat(0, mk(1, 2, 3, 0, 0), 5'b00111, 2'd0, 1'b0);
        expectBeat(0, mk(0, 4, 5, 6, 0), 5'b01110, 2'd1, 1'b0);
        expectBeat(0, mk(0, 0, 7, 8, 9), 5'b11100, 2'd2, 1'b1);
        applyStimulus(0, seq9(1), 9'h1FF, 1'b0);
        checkOutput("latency_valid", 64'(out_valid_a), 64'd1);
        repeat (3) tick();
        checkOutput("idle_after_tile", 64'(out_valid_a), 64'd0);
        checkOutput("idle_data_cleared", 64'(out_data_a), 64'd0);
        checkOutput("rows_drained", 64'(q_a.size()), 64'd0);

        // 3x3 column mode
        expectBeat(0, mk(1, 4, 7, 0, 0), 5'b00111, 2'd0, 1'b0);
        expectBeat(0, mk(0, 2, 5, 8, 0), 5'b01110, 2'd1, 1'b0);
        expectBeat(0, mk(0, 0, 3, 6, 9), 5'b11100, 2'd2, 1'b1);
        applyStimulus(0, seq9(1), 9'h1FF, 1'b1);
        waitDrain(0);
        tick();

        // Backpressure during beat 1
        expectBeat(0, mk(1, 2, 3, 0, 0), 5'b00111, 2'd0, 1'b0);
        expectBeat(0, mk(0, 4, 5, 6, 0), 5'b01110, 2'd1, 1'b0);
        expectBeat(0, mk(0, 0, 7, 8, 9), 5'b11100, 2'd2, 1'b1);
        applyStimulus(0, seq9(1), 9'h1FF, 1'b0);
        tick();
        out_ready_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_data", 64'(out_data_a), 64'(mk(0, 4, 5, 6, 0)));
            checkOutput("stall_beat", 64'(out_beat_a), 64'd1);
            checkOutput("stall_in_ready", 64'(in_ready_a), 64'd0);
        end
`ifdef SKEW_TILE_COUNT_EN
        checkOutput("stall_cycles", 64'(stall_cycles_a), 64'd3);
`endif
        out_ready_a = 1'b1;
        tick();
        checkOutput("after_stall_beat", 64'(out_beat_a), 64'd2);
        waitDrain(0);
        tick();

        // Back-to-back tiles with in_valid held high
`ifdef SKEW_TILE_COUNT_EN
        tc_before = tile_count_a;
`endif
        expectBeat(0, mk(1, 2, 3, 0, 0), 5'b00111, 2'd0, 1'b0);
        expectBeat(0, mk(0, 4, 5, 6, 0), 5'b01110, 2'd1, 1'b0);
        expectBeat(0, mk(0, 0, 7, 8, 9), 5'b11100, 2'd2, 1'b1);
        expectBeat(0, mk(10, 11, 12, 0, 0), 5'b00111, 2'd0, 1'b0);
        expectBeat(0, mk(0, 13, 14, 15, 0), 5'b01110, 2'd1, 1'b0);
        expectBeat(0, mk(0, 0, 16, 17, 18), 5'b11100, 2'd2, 1'b1);
        in_tile_a = seq9(1); in_mask_a = 9'h1FF; in_transpose_a = 1'b0; in_valid_a = 1'b1;
        tick();
        in_tile_a = seq9(10);
        checkOutput("b2b_ready_low", 64'(in_ready_a), 64'd0);
        repeat (2) tick();
        checkOutput("b2b_ready_on_last", 64'(in_ready_a), 64'd1);
        tick();
        in_valid_a = 1'b0;
        checkOutput("b2b_no_gap_valid", 64'(out_valid_a), 64'd1);
        checkOutput("b2b_no_gap_beat", 64'(out_beat_a), 64'd0);
        waitDrain(0);
        tick();
`ifdef SKEW_TILE_COUNT_EN
        checkOutput("tile_count_delta", 64'(16'(tile_count_a - tc_before)), 64'd2);
`endif

        // Masked element then reset mid-tile
        expectBeat(0, mk(1, 2, 3, 0, 0), 5'b00111, 2'd0, 1'b0);
        expectBeat(0, mk(0, 4, 5, 6, 0), 5'b01010, 2'd1, 1'b0);
        applyStimulus(0, seq9(1), 9'h1EF, 1'b0);
        tick();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid_a), 64'd0);
        checkOutput("rst_out_data", 64'(out_data_a), 64'd0);
        checkOutput("rst_out_mask", 64'(out_mask_a), 64'd0);
        checkOutput("rst_out_beat", 64'(out_beat_a), 64'd0);
        checkOutput("rst_out_last", 64'(out_last_a), 64'd0);
        checkOutput("mask_beats_seen", 64'(q_a.size()), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checkOutput("post_rst_valid", 64'(out_valid_a), 64'd0);
        checkOutput("post_rst_in_ready", 64'(in_ready_a), 64'd1);

        // 2x4 row mode, then column mode
        expectBeat(1, mk(1, 2, 3, 4, 0), 5'b01111, 2'd0, 1'b0);
        expectBeat(1, mk(0, 5, 6, 7, 8), 5'b11110, 2'd1, 1'b1);
        applyStimulus(1, {8'h0, seq8(1)}, 9'h0FF, 1'b0);
        waitDrain(1);
        tick();
        expectBeat(1, mk(1, 5, 0, 0, 0), 5'b00011, 2'd0, 1'b0);
        expectBeat(1, mk(0, 2, 6, 0, 0), 5'b00110, 2'd1, 1'b0);
        expectBeat(1, mk(0, 0, 3, 7, 0), 5'b01100, 2'd2, 1'b0);
        expectBeat(1, mk(0, 0, 0, 4, 8), 5'b11000, 2'd3, 1'b1);
        applyStimulus(1, {8'h0, seq8(1)}, 9'h0FF, 1'b1);
        waitDrain(1);
        repeat (2) tick();
        checkOutput("b_idle", 64'(out_valid_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skew_tile_streamer.md
Name: skew_tile_streamer

Overview:
- Parametrised successor to the fixed 3x3 row shifter that skews matrix rows into a systolic array.
- Accepts a ROWS x COLS tile through a valid/ready handshake and emits one skewed beat per cycle. Beat k carries row k (or column k in transpose mode), placed at lane offset k, with zeros elsewhere.
- Per-element valid masks travel with the data.
- Output-side backpressure and back-to-back tiles are supported. The block sits between the tile buffer and the systolic PE array edge.

Parameters:
- ROWS, 3, tile rows.
- COLS, 3, tile columns.
- DATA_WIDTH, 8, bits per element.
- LANES (localparam), ROWS+COLS-1, output lane count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  tile offered.
- in_ready  out  1  tile accepted when in_valid && in_ready.
- in_tile  in  ROWS*COLS*DATA_WIDTH  element (r,c) at bits [(r*COLS+c)*DATA_WIDTH +: DATA_WIDTH].
- in_mask  in  ROWS*COLS  element (r,c) valid at bit r*COLS+c.
- in_transpose  in  1  0: stream rows; 1: stream columns; sampled at accept.
- out_valid  out  1  beat present.
- out_ready  in  1  sink accepts beat.
- out_data  out  LANES*DATA_WIDTH  lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- out_mask  out  LANES  lane valid bits.
- out_beat  out  clog2(max(ROWS,COLS))  index of current beat.
- out_last  out  1  final beat of tile.

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, out_data=0, out_mask=0, out_beat=0, out_last=0, tile buffer cleared. Reset mid-tile abandons the tile with no further beats.
- States: IDLE, STREAM.
- in_ready = (state==IDLE) || (state==STREAM && out_last && out_ready). This is combinational from out_ready and is required for zero-bubble back-to-back tiles.
- Accept (in_valid && in_ready): register in_tile, in_mask and in_transpose; set beat counter k=0; state=STREAM.
- First beat is registered: out_valid=1 in the cycle after accept. Latency is 1 cycle.
- Beat count NB = ROWS when transpose=0, COLS when transpose=1. Vector length L = COLS when transpose=0, ROWS when transpose=1.
- Beat k, transpose=0:
  - Lane k+i = element (k,i), for i in 0..L-1.
  - All other lanes: data 0, mask 0.
  - Lane mask = in_mask of the element.
- Beat k, transpose=1: lane k+i = element (i,k). Masking is otherwise identical to transpose=0.
- out_beat = k. out_last = (k==NB-1).
- Advance when out_valid && out_ready: k increments.
  - If out_last is set and a new tile is accepted in the same cycle, the next cycle shows beat 0 of the new tile.
  - If out_last is set and no new tile is accepted, the next cycle has out_valid=0 and state=IDLE, and the output data/mask registers are cleared to 0.
- Stall (out_valid && !out_ready): out_data, out_mask, out_beat and out_last hold exactly. No tile is accepted.
- in_tile, in_mask and in_transpose changes after accept have no effect on the tile in flight.
- ROWS=1 or COLS=1 is legal:
  - The degenerate beat count is 1, so out_last is 1 on the first beat.
  - ROWS=COLS=1 gives LANES=1.
- Unsigned pass-through; no arithmetic on data.

Optional Feature:
- Macro SKEW_TILE_COUNT_EN.
- When defined:
  - Adds output port tile_count (16 bits), reset 0.
  - Increments by 1 (wrapping at 65535 to 0) on each accepted final beat (out_valid && out_ready && out_last).
  - Adds output port stall_cycles (16 bits, saturating at 65535), counting cycles with out_valid && !out_ready.
- When undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- ROWS=COLS=3, tile 1..9 row-major, all masks 1, transpose=0, out_ready=1. Expect three beats on consecutive cycles, starting the cycle after accept:
  - [1,2,3,0,0]
  - [0,4,5,6,0]
  - [0,0,7,8,9]
  - out_last on beat 2 only; out_mask 11100, 01110, 00111 (lane 0 first).
- Same tile, transpose=1. Expect beats [1,4,7,0,0], [0,2,5,8,0], [0,0,3,6,9].
- ROWS=2, COLS=4, elements 1..8, transpose=0. Expect [1,2,3,4,0], [0,5,6,7,8]. With transpose=1, expect 4 beats: [1,5,0,0,0], [0,2,6,0,0], [0,0,3,7,0], [0,0,0,4,8].
- Backpressure: hold out_ready=0 for 3 cycles during beat 1. Expect the beat-1 outputs to be stable, in_ready=0 throughout, then beat 2 one cycle after out_ready rises. With SKEW_TILE_COUNT_EN, stall_cycles=3.
- Back-to-back: second tile (10..18) presented with in_valid held high. Expect it accepted in the out_last cycle, with beat [10,11,12,0,0] immediately following [0,0,7,8,9] with no gap. With SKEW_TILE_COUNT_EN, tile_count=2 after both tiles.
- Mask and reset: in_mask bit (1,1)=0 gives lane 2 of beat 1 with mask 0 and data 5. Assert rst during beat 1: out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and no stale beat appears.
